// File: rtl/inst_sequencer.sv
// Instruction sequencer: host-loaded instruction RAM, credit-based prefetch into a
// small FIFO, and a valid/ready issue port with single-run and loop modes.
module inst_sequencer #(
    parameter int unsigned          INST_WIDTH = 72,
    parameter int unsigned          ADDR_WIDTH = 11,
    parameter int unsigned          CMD_WIDTH  = 4,
    parameter logic [CMD_WIDTH-1:0] CMD_END    = 4'hF,
    parameter int unsigned          RD_LATENCY = 2,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter bit                   AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INST_WIDTH-1:0] wr_data_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic                  wr_en_in,
    input  logic                  start_in,
    input  logic                  loop_in,
    input  logic                  abort_in,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic                  loaded_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  wr_err_out,
    output logic [1:0]            state_out
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    loaded_q, loaded_dly_q, wr_err_q;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic [INST_WIDTH-1:0]   data_pipe_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   addr_pipe_q [RD_LATENCY];
    logic [INST_WIDTH-1:0]   mem_q       [2**ADDR_WIDTH];
    logic [INST_WIDTH-1:0]   fifo_inst_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]           count_q;
    logic [CW-1:0]           in_flight, occupancy;

    logic                    host_wr, ret_vld, ret_end, push, pop, fifo_valid;
    logic                    end_pop, rd_en, auto_go;
    logic [INST_WIDTH-1:0]   ret_data, head_inst;
    logic [ADDR_WIDTH-1:0]   ret_addr, head_pc;

    assign host_wr    = wr_en_in && (state_q == S_IDLE);
    assign ret_vld    = vld_q[RD_LATENCY-1];
    assign ret_data   = data_pipe_q[RD_LATENCY-1];
    assign ret_addr   = addr_pipe_q[RD_LATENCY-1];
    assign ret_end    = (ret_data[CMD_WIDTH-1:0] == CMD_END);
    assign push       = ret_vld && (state_q == S_RUN) && !abort_in;
    assign fifo_valid = (count_q != '0);
    assign head_inst  = fifo_inst_q[rd_ptr_q];
    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign pop        = fifo_valid && inst_ready_in && !abort_in;
    assign end_pop    = pop && (state_q == S_DRAIN) && (head_inst[CMD_WIDTH-1:0] == CMD_END);
    assign auto_go    = AUTO_START && loaded_q && !loaded_dly_q;

    // Credit counts words already queued plus reads still in the RAM pipeline.
    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(vld_q[i]);
        end
        occupancy = CW'(count_q) + in_flight;
        rd_en = (state_q == S_RUN) && (occupancy < CW'(FIFO_DEPTH))
                && !(push && ret_end) && !abort_in;
        vld_d = (vld_q << 1) | RD_LATENCY'(rd_en);
        // Reads issued behind the END word are dropped by clearing their tags.
        if (abort_in || (push && ret_end)) begin
            vld_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = rd_en ? pc_q + 1'b1 : pc_q;
        unique case (state_q)
            S_IDLE: begin
                if ((start_in && loaded_q) || auto_go) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (push && ret_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (end_pop) begin
                    state_d = loop_in ? S_RUN : S_IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_in) begin
            state_d = S_IDLE;
            pc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            vld_q        <= '0;
            loaded_q     <= 1'b0;
            loaded_dly_q <= 1'b0;
            wr_err_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            vld_q        <= vld_d;
            loaded_dly_q <= loaded_q;
            if (host_wr && (wr_data_in[CMD_WIDTH-1:0] == CMD_END)) begin
                loaded_q <= 1'b1;
            end
            if (wr_en_in && (state_q != S_IDLE)) begin
                wr_err_q <= 1'b1;
            end
            if (abort_in) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (host_wr) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    always_ff @(posedge clk) begin
        data_pipe_q[0] <= mem_q[pc_q];
        addr_pipe_q[0] <= pc_q;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            data_pipe_q[i] <= data_pipe_q[i-1];
            addr_pipe_q[i] <= addr_pipe_q[i-1];
        end
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= ret_data;
            fifo_pc_q[wr_ptr_q]   <= ret_addr;
        end
    end

    assign inst_out       = fifo_valid ? head_inst : '0;
    assign pc_out         = fifo_valid ? head_pc : '0;
    assign inst_valid_out = fifo_valid;
    assign loaded_out     = loaded_q;
    assign busy_out       = (state_q != S_IDLE);
    assign done_out       = end_pop;
    assign wr_err_out     = wr_err_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a cycle table for a short program plus
// hand-written sequences for stall, loop, early END, abort, busy writes, reset and pc wrap.
module tb_inst_sequencer;

    localparam int unsigned IW = 72;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset_n, wr_en_in, start_in, loop_in, abort_in, inst_ready_in;
    logic [IW-1:0] wr_data_in, inst_out;
    logic [AW-1:0] wr_addr_in, pc_out;
    logic          inst_valid_out, loaded_out, busy_out, done_out, wr_err_out;
    logic [1:0]    state_out;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cyc = 0;
    int          xfer_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inst_sequencer #(
        .INST_WIDTH(72), .ADDR_WIDTH(11), .CMD_WIDTH(4), .CMD_END(4'hF),
        .RD_LATENCY(2), .FIFO_DEPTH(4), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_data_in(wr_data_in), .wr_addr_in(wr_addr_in), .wr_en_in(wr_en_in),
        .start_in(start_in), .loop_in(loop_in), .abort_in(abort_in),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid_out(inst_valid_out),
        .inst_ready_in(inst_ready_in), .loaded_out(loaded_out), .busy_out(busy_out),
        .done_out(done_out), .wr_err_out(wr_err_out), .state_out(state_out)
    );

    typedef struct {
        logic          ready;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [IW-1:0] exp_inst;
        logic          exp_done;
        logic [1:0]    exp_state;
    } vec_t;

    vec_t          tbl [9];
    logic [IW-1:0] t1w [3];
    logic [IW-1:0] tbw [10];

    function automatic logic [IW-1:0] mkw(input logic [31:0] tag, input logic [3:0] op);
        return {tag, ~tag, 4'h0, op};
    endfunction

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
        wr_en_in   = 1'b1;
        wr_addr_in = a;
        wr_data_in = d;
        next();
        wr_en_in   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        next();
        next();
        reset_n = 1'b1;
    endtask

    task automatic load10();
        for (int i = 0; i < 10; i++) wr(AW'(i), tbw[i]);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " inst"},   inst_out, '0);
        chk({nm, " pc"},     IW'(pc_out), '0);
        chk({nm, " valid"},  IW'(inst_valid_out), '0);
        chk({nm, " busy"},   IW'(busy_out), '0);
        chk({nm, " done"},   IW'(done_out), '0);
        chk({nm, " loaded"}, IW'(loaded_out), '0);
        chk({nm, " wr_err"}, IW'(wr_err_out), '0);
        chk({nm, " state"},  IW'(state_out), '0);
    endtask

    // Call at posedge+1; waits (bounded) for the next transfer and checks it.
    task automatic get_xfer(input logic [AW-1:0] epc, input logic [IW-1:0] einst,
                            input logic edone, input string nm);
        int t = 0;
        @(negedge clk);
        while (!(inst_valid_out && inst_ready_in) && t < 40) begin
            next();
            @(negedge clk);
            t++;
        end
        chk({nm, " timeout"}, IW'(t >= 40), '0);
        if (t < 40) begin
            xfer_cyc = cyc;
            chk({nm, " pc"},   IW'(pc_out), IW'(epc));
            chk({nm, " inst"}, inst_out, einst);
            chk({nm, " done"}, IW'(done_out), IW'(edone));
        end
        next();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        int s_cyc, prev, extra;

        t1w[0] = mkw(32'h11, 4'h1);
        t1w[1] = mkw(32'h12, 4'h2);
        t1w[2] = mkw(32'h13, 4'hF);
        for (int i = 0; i < 10; i++) tbw[i] = mkw(32'h200 + i, (i == 9) ? 4'hF : 4'h1);

        // Cycle 0 is the first cycle loaded_out is high after the END write.
        tbl[0] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd1};
        tbl[2] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd1};
        tbl[3] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd1};
        tbl[4] = '{1'b1, 1'b1, 11'd0, t1w[0], 1'b0, 2'd1};
        tbl[5] = '{1'b1, 1'b1, 11'd1, t1w[1], 1'b0, 2'd1};
        tbl[6] = '{1'b1, 1'b1, 11'd2, t1w[2], 1'b1, 2'd2};
        tbl[7] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd0};
        tbl[8] = '{1'b1, 1'b0, 11'd0, '0,     1'b0, 2'd0};

        reset_n = 1'b0; wr_en_in = 1'b0; wr_addr_in = '0; wr_data_in = '0;
        start_in = 1'b0; loop_in = 1'b0; abort_in = 1'b0; inst_ready_in = 1'b0;

        // Reset state, then 3-word program with auto start.
        do_reset();
        @(negedge clk);
        chk_zero("reset");
        next();
        inst_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) wr(AW'(i), t1w[i]);
        for (int i = 0; i < 9; i++) begin
            inst_ready_in = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("t1[%0d] valid", i), IW'(inst_valid_out), IW'(tbl[i].exp_valid));
            chk($sformatf("t1[%0d] pc", i),    IW'(pc_out), IW'(tbl[i].exp_pc));
            chk($sformatf("t1[%0d] inst", i),  inst_out, tbl[i].exp_inst);
            chk($sformatf("t1[%0d] done", i),  IW'(done_out), IW'(tbl[i].exp_done));
            chk($sformatf("t1[%0d] state", i), IW'(state_out), IW'(tbl[i].exp_state));
            chk($sformatf("t1[%0d] loaded", i), IW'(loaded_out), 72'd1);
            next();
        end

        // Consumer stall: FIFO fills, head held stable, then drains in order.
        do_reset();
        inst_ready_in = 1'b0;
        load10();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 8) begin
                chk($sformatf("t2 stall%0d valid", i), IW'(inst_valid_out), 72'd1);
                chk($sformatf("t2 stall%0d pc", i),    IW'(pc_out), '0);
                chk($sformatf("t2 stall%0d inst", i),  inst_out, tbw[0]);
            end
            next();
        end
        inst_ready_in = 1'b1;
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            get_xfer(AW'(k), tbw[k], k == 9, $sformatf("t2 x%0d", k));
            if (k > 0) chk($sformatf("t2 gap%0d", k), IW'(xfer_cyc - prev), 72'd1);
            prev = xfer_cyc;
        end
        @(negedge clk);
        chk("t2 end state", IW'(state_out), '0);
        next();

        // Loop mode, then leave loop before the last END pop.
        do_reset();
        loop_in = 1'b1;
        wr(0, mkw(32'h30, 4'h1));
        wr(1, mkw(32'h31, 4'hF));
        for (int it = 0; it < 3; it++) begin
            get_xfer(0, mkw(32'h30, 4'h1), 1'b0, $sformatf("t3 it%0d pc0", it));
            get_xfer(1, mkw(32'h31, 4'hF), 1'b1, $sformatf("t3 it%0d pc1", it));
        end
        loop_in = 1'b0;
        get_xfer(0, mkw(32'h30, 4'h1), 1'b0, "t3 last pc0");
        get_xfer(1, mkw(32'h31, 4'hF), 1'b1, "t3 last pc1");
        @(negedge clk);
        chk("t3 idle state", IW'(state_out), '0);
        chk("t3 idle valid", IW'(inst_valid_out), '0);
        next();

        // END at address 0: words fetched behind it never appear.
        do_reset();
        wr(1, mkw(32'h41, 4'h2));
        wr(2, mkw(32'h42, 4'h3));
        wr(3, mkw(32'h43, 4'h5));
        wr(0, mkw(32'h40, 4'hF));
        get_xfer(0, mkw(32'h40, 4'hF), 1'b1, "t4 end");
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_valid_out) extra++;
            next();
        end
        chk("t4 extra words", IW'(extra), '0);
        chk("t4 state", IW'(state_out), '0);

        // Abort with 3 queued entries, then restart from pc 0.
        do_reset();
        inst_ready_in = 1'b0;
        load10();
        for (int i = 0; i < 6; i++) next();
        abort_in = 1'b1;
        @(negedge clk);
        chk("t5 pre valid", IW'(inst_valid_out), 72'd1);
        chk("t5 pre pc", IW'(pc_out), '0);
        chk("t5 pre done", IW'(done_out), '0);
        next();
        abort_in = 1'b0;
        @(negedge clk);
        chk("t5 post valid", IW'(inst_valid_out), '0);
        chk("t5 post state", IW'(state_out), '0);
        chk("t5 post busy", IW'(busy_out), '0);
        chk("t5 post done", IW'(done_out), '0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            next();
            @(negedge clk);
            if (inst_valid_out || done_out) extra++;
        end
        chk("t5 flushed", IW'(extra), '0);
        next();
        start_in = 1'b1;
        @(negedge clk);
        s_cyc = cyc;
        next();
        start_in = 1'b0;
        inst_ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            get_xfer(AW'(k), tbw[k], k == 9, $sformatf("t5 x%0d", k));
            if (k == 0) chk("t5 start latency", IW'(xfer_cyc - s_cyc), 72'd4);
        end

        // Write while busy is dropped and flagged; reset mid-run clears everything.
        do_reset();
        inst_ready_in = 1'b1;
        load10();
        next();
        next();
        wr(3, mkw(32'hDEAD, 4'h1));
        @(negedge clk);
        chk("t6 wr_err set", IW'(wr_err_out), 72'd1);
        next();
        for (int k = 0; k < 10; k++) get_xfer(AW'(k), tbw[k], k == 9, $sformatf("t6 x%0d", k));
        @(negedge clk);
        chk("t6 idle state", IW'(state_out), '0);
        chk("t6 wr_err sticky", IW'(wr_err_out), 72'd1);
        next();
        start_in = 1'b1;
        next();
        start_in = 1'b0;
        next();
        next();
        next();
        @(negedge clk);
        chk("t6 running", IW'(busy_out), 72'd1);
        next();
        reset_n = 1'b0;
        next();
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero("t6 reset");
        next();

        // No END in RAM: fetch pc wraps from the top address back to 0.
        do_reset();
        wr(0, mkw(32'h70, 4'hF));
        abort_in = 1'b1;
        next();
        abort_in = 1'b0;
        @(negedge clk);
        chk("t7 held idle", IW'(state_out), '0);
        next();
        for (int a = 0; a < 2048; a++) wr(AW'(a), mkw(32'(a), 4'h1));
        start_in = 1'b1;
        next();
        start_in = 1'b0;
        for (int k = 0; k < 2050; k++) begin
            get_xfer(AW'(k), mkw(32'(k % 2048), 4'h1), 1'b0, $sformatf("t7 x%0d", k));
        end
        abort_in = 1'b1;
        next();
        abort_in = 1'b0;
        @(negedge clk);
        chk("t7 abort state", IW'(state_out), '0);
        chk("t7 abort valid", IW'(inst_valid_out), '0);
        chk("t7 wr_err", IW'(wr_err_out), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
